lsu_mem_access: RTL



---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_extend.sv | 26 ++
 rtl/lsu_mem_access.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared access-type codes, sign codes and FSM state type for the load/store unit.
package lsu_pkg;

    localparam logic [3:0] BYTE   = 4'b0001;
    localparam logic [3:0] HALF   = 4'b0011;
    localparam logic [3:0] WORD   = 4'b1111;

    localparam logic       SIGN   = 1'b0;
    localparam logic       UNSIGN = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } lsu_state_e;

    // Any code outside the three legal ones behaves as a full-word access.
    function automatic logic [3:0] normType(input logic [3:0] t);
        logic [3:0] r;
        if ((t == BYTE) || (t == HALF)) r = t;
        else                            r = WORD;
        return r;
    endfunction

    function automatic logic crossesWord(input logic [3:0] t, input logic [1:0] off);
        return ((t == HALF) && (off == 2'd3)) || ((t == WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Right-aligns load bytes from a {hi,lo} word pair by byte offset, then sign/zero-extends per access type.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] lo_i,
    input  logic [DATAWIDTH-1:0] hi_i,
    input  logic [1:0]           off_i,
    input  logic [3:0]           type_i,
    input  logic                 sign_i,
    output logic [DATAWIDTH-1:0] data_o
);

    logic [DATAWIDTH-1:0] raw;

    always_comb begin
        raw = DATAWIDTH'({hi_i, lo_i} >> {off_i, 3'b000});
        case (type_i)
            BYTE:    data_o = {{(DATAWIDTH-8){~sign_i & raw[7]}}, raw[7:0]};
            HALF:    data_o = {{(DATAWIDTH-16){~sign_i & raw[15]}}, raw[15:0]};
            default: data_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit between MEM stage and a word-wide byte-strobed memory port.
// Macro LSU_MISALIGN_SPLIT_EN: word-crossing accesses split into two beats; otherwise they are rejected with resp_err.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int ADDRWIDTH     = 32,
    parameter int DATAWIDTH     = 32,
    parameter int WORDTYPEWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRWIDTH-1:0]     req_addr,
    input  logic [DATAWIDTH-1:0]     req_wdata,
    input  logic [WORDTYPEWIDTH-1:0] req_type,
    input  logic                     req_sign,
    output logic                     resp_valid,
    output logic [DATAWIDTH-1:0]     resp_rdata,
    output logic                     resp_err,
    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [ADDRWIDTH-1:0]     mem_addr,
    output logic [DATAWIDTH-1:0]     mem_wdata,
    input  logic [DATAWIDTH-1:0]     mem_rdata,
    input  logic                     mem_ready
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int MASKW = 8;
`else
    localparam int MASKW = 4;
`endif

    lsu_state_e           state_q, state_d;
    logic                 write_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [3:0]           type_q;
    logic                 sign_q;
    logic                 err_q;
    logic [MASKW-1:0]     mask_q;
    logic [DATAWIDTH-1:0] lo_q;

    logic                 accept;
    logic [3:0]           reqType;
    logic [MASKW-1:0]     reqMask;
    logic                 errNext;
    logic [1:0]           off;
    logic [ADDRWIDTH-1:0] wordAddr;
    logic [DATAWIDTH-1:0] hiWord;
    logic [DATAWIDTH-1:0] loadData;

    assign reqType  = normType(req_type);
    assign reqMask  = MASKW'({4'b0000, reqType} << req_addr[1:0]);
    assign accept   = req_valid && (state_q == IDLE);
    assign off      = addr_q[1:0];
    assign wordAddr = {addr_q[ADDRWIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [DATAWIDTH-1:0] hi_q;

    assign errNext = 1'b0;
    assign hiWord  = hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
        end else if (accept) begin
            hi_q <= '0;
        end else if ((state_q == BEAT1) && mem_ready) begin
            hi_q <= mem_rdata;
        end
    end
`else
    assign errNext = crossesWord(reqType, req_addr[1:0]);
    assign hiWord  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                type_q  <= reqType;
                sign_q  <= req_sign;
                err_q   <= errNext;
                mask_q  <= reqMask;
            end
            if ((state_q == BEAT0) && mem_ready) begin
                lo_q <= mem_rdata;
            end
        end
    end

    lsu_load_extend #(
        .DATAWIDTH(DATAWIDTH)
    ) u_extend (
        .lo_i   (lo_q),
        .hi_i   (hiWord),
        .off_i  (off),
        .type_i (type_q),
        .sign_i (sign_q),
        .data_o (loadData)
    );

    // Beat outputs are held from registered request fields so they stay stable across memory stalls.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = errNext ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                mem_en    = 1'b1;
                mem_addr  = wordAddr;
                mem_we    = write_q ? mask_q[3:0] : 4'b0000;
                mem_wdata = wdata_q << {off, 3'b000};
                if (mem_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = (mask_q[7:4] != 4'b0000) ? BEAT1 : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: begin
                mem_en    = 1'b1;
                mem_addr  = wordAddr + ADDRWIDTH'(4);
                mem_we    = write_q ? mask_q[7:4] : 4'b0000;
                mem_wdata = wdata_q >> (6'd32 - {1'b0, off, 3'b000});
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? '0 : loadData;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
